// File: rtl/id_operand_unit_pkg.sv
// Shared widths and field offsets for the WB/EX/MEM -> ID buses.
// Producers (WB, EX, MEM) and this consumer must all slice buses with these constants.
// Also holds the RAW hit helper used by both operand ports.
package id_operand_unit_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;
  localparam int RF_NREG = 2 ** RF_AW;

  localparam int WIDTH_WS_TO_DS_BUS = 38;
  localparam int WIDTH_ES_TO_DS_BUS = 6;
  localparam int WIDTH_MS_TO_DS_BUS = 6;

  // ws_to_ds_bus = {we, waddr[4:0], wdata[31:0]}
  localparam int WS_WDATA_LSB = 0;
  localparam int WS_WADDR_LSB = 32;
  localparam int WS_WE_BIT    = 37;

  // es_to_ds_bus / ms_to_ds_bus = {we, dest[4:0]}
  localparam int FWD_DEST_LSB = 0;
  localparam int FWD_WE_BIT   = 5;

  // A source register collides with an in-flight EX or MEM write. r0 never collides,
  // so a dest of 0 cannot match a live source index.
  function automatic logic raw_hit(input logic             used,
                                   input logic [RF_AW-1:0] raddr,
                                   input logic             es_we,
                                   input logic [RF_AW-1:0] es_dest,
                                   input logic             ms_we,
                                   input logic [RF_AW-1:0] ms_dest);
    return used && (raddr != '0) &&
           ((es_we && (es_dest == raddr)) || (ms_we && (ms_dest == raddr)));
  endfunction

endpackage

// File: rtl/id_operand_unit_if.sv
// Operand/forwarding interface between the ID stage and the operand unit.
// The ID side (master) drives indices, stage buses and valid; the unit (slave) returns
// operands, hazard and the stall counter.
interface id_operand_unit_if #(
  parameter int CNT_W = 32
);
  import id_operand_unit_pkg::*;

  logic                          ds_valid;
  logic [RF_AW-1:0]              rf_raddr1;
  logic [RF_AW-1:0]              rf_raddr2;
  logic                          rs1_used;
  logic                          rs2_used;
  logic [WIDTH_WS_TO_DS_BUS-1:0] ws_to_ds_bus;
  logic [WIDTH_ES_TO_DS_BUS-1:0] es_to_ds_bus;
  logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus;
  logic [RF_XLEN-1:0]            rf_rdata1;
  logic [RF_XLEN-1:0]            rf_rdata2;
  logic                          ds_hazard;
  logic [CNT_W-1:0]              stall_cnt;

  modport master (
    output ds_valid, rf_raddr1, rf_raddr2, rs1_used, rs2_used,
           ws_to_ds_bus, es_to_ds_bus, ms_to_ds_bus,
    input  rf_rdata1, rf_rdata2, ds_hazard, stall_cnt
  );

  modport slave (
    input  ds_valid, rf_raddr1, rf_raddr2, rs1_used, rs2_used,
           ws_to_ds_bus, es_to_ds_bus, ms_to_ds_bus,
    output rf_rdata1, rf_rdata2, ds_hazard, stall_cnt
  );

endinterface

// File: rtl/id_operand_unit_regfile_2r1w.sv
// Architectural register file: 2 async read ports, 1 sync write port, r0 hard-wired to 0.
// Latency: reads 0 cycles, writes visible the cycle after the write edge.
// Backpressure: none, the write port is always accepted.
module regfile_2r1w #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  localparam int NREG = 2 ** REG_AW;

  logic [XLEN-1:0] r_mem [NREG];

  // Synchronous clear of the whole array; otherwise commit the write, dropping r0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: register file, same-cycle WB bypass, EX/MEM RAW hazard, stall counter.
// Latency: operands and hazard are combinational (0 cycles); stall_cnt is registered.
// Backpressure: raises ds_hazard to hold ID; never blocks write-back.
module id_operand_unit #(
  parameter int XLEN   = id_operand_unit_pkg::RF_XLEN,
  parameter int REG_AW = id_operand_unit_pkg::RF_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  id_operand_unit_if.slave  bus
);
  import id_operand_unit_pkg::*;

  logic              w_ws_we;
  logic [REG_AW-1:0] w_ws_waddr;
  logic [XLEN-1:0]   w_ws_wdata;
  logic              w_es_we;
  logic [REG_AW-1:0] w_es_dest;
  logic              w_ms_we;
  logic [REG_AW-1:0] w_ms_dest;
  logic [XLEN-1:0]   w_rf_rdata1;
  logic [XLEN-1:0]   w_rf_rdata2;
  logic [XLEN-1:0]   w_rdata1;
  logic [XLEN-1:0]   w_rdata2;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_hazard;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_ws_we    = bus.ws_to_ds_bus[WS_WE_BIT];
  assign w_ws_waddr = bus.ws_to_ds_bus[WS_WADDR_LSB +: REG_AW];
  assign w_ws_wdata = bus.ws_to_ds_bus[WS_WDATA_LSB +: XLEN];
  assign w_es_we    = bus.es_to_ds_bus[FWD_WE_BIT];
  assign w_es_dest  = bus.es_to_ds_bus[FWD_DEST_LSB +: REG_AW];
  assign w_ms_we    = bus.ms_to_ds_bus[FWD_WE_BIT];
  assign w_ms_dest  = bus.ms_to_ds_bus[FWD_DEST_LSB +: REG_AW];

  regfile_2r1w #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .resetn   (resetn),
    .i_we     (w_ws_we),
    .i_waddr  (w_ws_waddr),
    .i_wdata  (w_ws_wdata),
    .i_raddr1 (bus.rf_raddr1),
    .i_raddr2 (bus.rf_raddr2),
    .o_rdata1 (w_rf_rdata1),
    .o_rdata2 (w_rf_rdata2)
  );

  // Port 1 operand: zero in reset or for r0, else WB write-through, else array contents.
  always_comb begin
    w_rdata1 = w_rf_rdata1;
    if (!resetn || (bus.rf_raddr1 == '0)) begin
      w_rdata1 = '0;
    end else if (w_ws_we && (w_ws_waddr == bus.rf_raddr1)) begin
      w_rdata1 = w_ws_wdata;
    end
  end

  // Port 2 operand: same selection as port 1.
  always_comb begin
    w_rdata2 = w_rf_rdata2;
    if (!resetn || (bus.rf_raddr2 == '0)) begin
      w_rdata2 = '0;
    end else if (w_ws_we && (w_ws_waddr == bus.rf_raddr2)) begin
      w_rdata2 = w_ws_wdata;
    end
  end

  // WB matches are bypassed above, so only EX and MEM can stall ID.
  assign w_hit1   = raw_hit(bus.rs1_used, bus.rf_raddr1, w_es_we, w_es_dest, w_ms_we, w_ms_dest);
  assign w_hit2   = raw_hit(bus.rs2_used, bus.rf_raddr2, w_es_we, w_es_dest, w_ms_we, w_ms_dest);
  assign w_hazard = resetn && bus.ds_valid && (w_hit1 || w_hit2);

  // Count stalled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.rf_rdata1 = w_rdata1;
  assign bus.rf_rdata2 = w_rdata2;
  assign bus.ds_hazard = w_hazard;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit: a full-width counter instance plus a 4-bit counter
// instance sharing the same stimulus; expectations are queued as stimulus is driven and
// popped against the outputs at the falling edge of each cycle.
module tb_id_operand_unit;

  localparam int K_RD1  = 0;
  localparam int K_RD2  = 1;
  localparam int K_HZ   = 2;
  localparam int K_CNT  = 3;
  localparam int K_CNT4 = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic resetn;

  exp_t        sb[$];
  int          checks;
  int          failures;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  id_operand_unit_if #(.CNT_W(32)) ifm ();
  id_operand_unit_if #(.CNT_W(4))  if4 ();

  assign if4.ds_valid     = ifm.ds_valid;
  assign if4.rf_raddr1    = ifm.rf_raddr1;
  assign if4.rf_raddr2    = ifm.rf_raddr2;
  assign if4.rs1_used     = ifm.rs1_used;
  assign if4.rs2_used     = ifm.rs2_used;
  assign if4.ws_to_ds_bus = ifm.ws_to_ds_bus;
  assign if4.es_to_ds_bus = ifm.es_to_ds_bus;
  assign if4.ms_to_ds_bus = ifm.ms_to_ds_bus;

  id_operand_unit #(.CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifm.slave)
  );

  id_operand_unit #(.CNT_W(4)) dut4 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD1:   obs = ifm.rf_rdata1;
        K_RD2:   obs = ifm.rf_rdata2;
        K_HZ:    obs = {31'd0, ifm.ds_hazard};
        K_CNT:   obs = ifm.stall_cnt;
        K_CNT4:  obs = {28'd0, if4.stall_cnt};
        default: obs = 'x;
      endcase
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock cycle: queue hazard/counter expectations, check at the falling edge,
  // advance the counter model, then let the rising edge commit.
  task automatic cycle(input string tag, input logic hz);
    expect_val({tag, "_hz"},   K_HZ,   {31'd0, hz});
    expect_val({tag, "_cnt"},  K_CNT,  m_cnt);
    expect_val({tag, "_cnt4"}, K_CNT4, {28'd0, m_cnt4});
    @(negedge clk);
    drain();
    if (!resetn) begin
      m_cnt  = '0;
      m_cnt4 = '0;
    end else if (hz) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    ifm.ws_to_ds_bus = {we, addr, data};
  endtask

  task automatic es(input logic we, input logic [4:0] dest);
    ifm.es_to_ds_bus = {we, dest};
  endtask

  task automatic ms(input logic we, input logic [4:0] dest);
    ifm.ms_to_ds_bus = {we, dest};
  endtask

  task automatic rd(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    ifm.rf_raddr1 = a1;
    ifm.rs1_used  = u1;
    ifm.rf_raddr2 = a2;
    ifm.rs2_used  = u2;
  endtask

  task automatic idle();
    ifm.ds_valid = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    es(1'b0, 5'd0);
    ms(1'b0, 5'd0);
    rd(5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_cnt    = '0;
    m_cnt4   = '0;
    resetn   = 1'b0;
    idle();

    // Reset held two cycles with hazard-causing and writing inputs present.
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd9);
    rd(5'd9, 1'b1, 5'd3, 1'b1);
    wb(1'b1, 5'd3, 32'h0000_0055);
    expect_val("rst0_rd1", K_RD1, 32'd0);
    expect_val("rst0_rd2", K_RD2, 32'd0);
    cycle("rst0", 1'b0);
    expect_val("rst1_rd1", K_RD1, 32'd0);
    expect_val("rst1_rd2", K_RD2, 32'd0);
    cycle("rst1", 1'b0);

    resetn = 1'b1;
    idle();
    rd(5'd5, 1'b1, 5'd3, 1'b1);
    expect_val("r5_zero", K_RD1, 32'd0);
    expect_val("r3_write_in_reset_dropped", K_RD2, 32'd0);
    cycle("rel", 1'b0);

    // Basic write/read and r0 behaviour.
    wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    expect_val("r0_read", K_RD1, 32'd0);
    cycle("wr_r3", 1'b0);
    wb(1'b1, 5'd0, 32'h0000_1234);
    rd(5'd3, 1'b1, 5'd0, 1'b1);
    expect_val("r3_read", K_RD1, 32'hDEAD_BEEF);
    expect_val("r0_no_bypass", K_RD2, 32'd0);
    cycle("wr_r0", 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    rd(5'd0, 1'b1, 5'd0, 1'b1);
    expect_val("r0_after_write", K_RD1, 32'd0);
    cycle("rd_r0", 1'b0);

    // Same-cycle write-through bypass.
    wb(1'b1, 5'd7, 32'h0000_0011);
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    cycle("wr_r7a", 1'b0);
    wb(1'b1, 5'd7, 32'h0000_0022);
    rd(5'd0, 1'b0, 5'd7, 1'b1);
    expect_val("bypass_r7", K_RD2, 32'h0000_0022);
    cycle("wr_r7b", 1'b0);
    wb(1'b1, 5'd8, 32'h0000_0099);
    rd(5'd7, 1'b1, 5'd3, 1'b1);
    expect_val("r7_holds_new", K_RD1, 32'h0000_0022);
    expect_val("r3_unaffected", K_RD2, 32'hDEAD_BEEF);
    cycle("wr_r8", 1'b0);

    // Hazard detection patterns.
    wb(1'b0, 5'd0, 32'd0);
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd9);
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    cycle("hz_es", 1'b1);
    rd(5'd9, 1'b0, 5'd0, 1'b0);
    cycle("hz_unused", 1'b0);
    es(1'b1, 5'd0);
    rd(5'd0, 1'b1, 5'd0, 1'b0);
    cycle("hz_dest0", 1'b0);
    es(1'b0, 5'd0);
    ms(1'b1, 5'd4);
    rd(5'd0, 1'b0, 5'd4, 1'b1);
    cycle("hz_ms", 1'b1);
    ifm.ds_valid = 1'b0;
    cycle("hz_novalid", 1'b0);
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd9);
    ms(1'b1, 5'd9);
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    cycle("hz_both", 1'b1);
    es(1'b0, 5'd0);
    ms(1'b0, 5'd0);
    wb(1'b1, 5'd9, 32'h0000_ABCD);
    expect_val("wb_bypass_no_hz", K_RD1, 32'h0000_ABCD);
    cycle("hz_wbonly", 1'b0);

    // Clear, then ten stalled cycles.
    resetn = 1'b0;
    idle();
    cycle("rst_mid0", 1'b0);
    resetn = 1'b1;
    wb(1'b1, 5'd3, 32'hCAFE_0003);
    cycle("wr_r3b", 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd9);
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("stall10", 1'b1);
    ifm.ds_valid = 1'b0;
    es(1'b0, 5'd0);
    rd(5'd3, 1'b1, 5'd0, 1'b0);
    expect_val("r3b_read", K_RD1, 32'hCAFE_0003);
    cycle("cnt10", 1'b0);

    // One-cycle reset pulse mid-run with a WB write and a would-be hazard.
    resetn = 1'b0;
    wb(1'b1, 5'd3, 32'h7777_7777);
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd3);
    rd(5'd3, 1'b1, 5'd3, 1'b1);
    expect_val("pulse_rd1", K_RD1, 32'd0);
    expect_val("pulse_rd2", K_RD2, 32'd0);
    cycle("rst_pulse", 1'b0);
    resetn = 1'b1;
    idle();
    rd(5'd3, 1'b1, 5'd0, 1'b0);
    expect_val("r3_cleared", K_RD1, 32'd0);
    cycle("after_pulse", 1'b0);

    // Run past the 4-bit counter limit.
    ifm.ds_valid = 1'b1;
    es(1'b1, 5'd9);
    rd(5'd9, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("sat", 1'b1);
    idle();
    cycle("sat_end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
